// File: rtl/simple_mux.sv
// simple_mux: two-input WIDTH-bit mux with a combinational output, a
// registered copy, and select-change monitoring (pulse + saturating count).
//
// Ports:
//   clk_i          clock, all state on rising edge
//   reset_i        asynchronous reset, active-high
//   a_i            data input, chosen when sel_i=0
//   b_i            data input, chosen when sel_i=1
//   sel_i          select
//   y_o            combinational mux output (independent of clock/reset)
//   y_q_o          y_o registered, 1-cycle latency
//   sel_q_o        sel_i registered
//   sel_chg_o      1-cycle pulse when the registered select changed on this edge
//   sel_chg_cnt_o  saturating count of select changes since reset
`timescale 1ns/1ps
module simple_mux #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_q_o,
  output logic             sel_q_o,
  output logic             sel_chg_o,
  output logic [CNT_W-1:0] sel_chg_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sel_diff;

  // Plain ?: keeps standard X-select semantics (a_i when inputs agree, else X).
  assign y_o = sel_i ? b_i : a_i;

  // Compare against the registered select; reset value 0 makes a first sel_i=1 a change.
  assign sel_diff = (sel_i != sel_q_o);

  // Registered copy, select history and change monitor.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      y_q_o         <= '0;
      sel_q_o       <= 1'b0;
      sel_chg_o     <= 1'b0;
      sel_chg_cnt_o <= '0;
    end else begin
      y_q_o     <= y_o;
      sel_q_o   <= sel_i;
      sel_chg_o <= sel_diff;
      // Holds at all-ones rather than wrapping.
      if (sel_diff && (sel_chg_cnt_o != CNT_MAX)) begin
        sel_chg_cnt_o <= sel_chg_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_simple_mux.sv
// Scoreboard bench for simple_mux: stimulus pushes expected post-edge state,
// a monitor pops and compares after every rising edge.
`timescale 1ns/1ps
module tb_simple_mux;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [0:0] a_i = 1'b0;
  logic [0:0] b_i = 1'b0;
  logic       sel_i = 1'b0;

  logic [0:0] y_o, y_q_o, y2, yq2;
  logic       sel_q_o, sel_chg_o, selq2, chg2;
  logic [7:0] sel_chg_cnt_o;
  logic [1:0] cnt2;

  simple_mux #(.WIDTH(1), .CNT_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .sel_i(sel_i),
    .y_o(y_o), .y_q_o(y_q_o), .sel_q_o(sel_q_o), .sel_chg_o(sel_chg_o),
    .sel_chg_cnt_o(sel_chg_cnt_o)
  );

  simple_mux #(.WIDTH(1), .CNT_W(2)) dut_s (
    .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .sel_i(sel_i),
    .y_o(y2), .y_q_o(yq2), .sel_q_o(selq2), .sel_chg_o(chg2),
    .sel_chg_cnt_o(cnt2)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       y_q;
    logic       sel_q;
    logic       chg;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pulses = 0;

  // Reference state for the expected-value model.
  logic m_sel_q;
  int   m_cnt8;
  int   m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, check comb output, queue expected state for the next edge.
  task automatic step(input logic a, input logic b, input logic s);
    exp_t e;
    a_i = a; b_i = b; sel_i = s;
    #1;
    chk("y_o", 32'(y_o), 32'(s ? b : a));
    chk("y_o_s", 32'(y2), 32'(s ? b : a));
    e.chg = (s != m_sel_q);
    if (e.chg) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    e.y_q   = s ? b : a;
    e.sel_q = s;
    e.cnt8  = 8'(m_cnt8);
    e.cnt2  = 2'(m_cnt2);
    m_sel_q = s;
    q.push_back(e);
    @(negedge clk_i);
  endtask

  // Asynchronous reset mid-cycle; returns at a falling edge with reset released.
  task automatic do_reset();
    logic [7:0] tt;
    tt = 8'b1101_1000;
    #2;
    reset_i = 1'b1;
    a_i = 1'b1; b_i = 1'b0; sel_i = 1'b1;
    #1;
    chk("rst_y_o", 32'(y_o), 32'd0);
    chk("rst_y_q", 32'(y_q_o), 32'd0);
    chk("rst_sel_q", 32'(sel_q_o), 32'd0);
    chk("rst_chg", 32'(sel_chg_o), 32'd0);
    chk("rst_cnt", 32'(sel_chg_cnt_o), 32'd0);
    chk("rst_cnt_s", 32'(cnt2), 32'd0);
    // Comb truth table while registers are held in reset.
    for (int i = 0; i < 8; i++) begin
      {a_i, b_i, sel_i} = 3'(i);
      #1;
      chk("tt_y_o", 32'(y_o), 32'(tt[i]));
    end
    a_i = 1'b1; b_i = 1'b0; sel_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_hold_y_q", 32'(y_q_o), 32'd0);
    chk("rst_hold_sel_q", 32'(sel_q_o), 32'd0);
    chk("rst_hold_cnt", 32'(sel_chg_cnt_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    m_sel_q = 1'b0;
    m_cnt8  = 0;
    m_cnt2  = 0;
  endtask

  // Monitor: outputs are valid every cycle; compare after each edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y_q_o", 32'(y_q_o), 32'(e.y_q));
        chk("sel_q_o", 32'(sel_q_o), 32'(e.sel_q));
        chk("sel_chg_o", 32'(sel_chg_o), 32'(e.chg));
        chk("sel_chg_cnt_o", 32'(sel_chg_cnt_o), 32'(e.cnt8));
        chk("y_q_o_s", 32'(yq2), 32'(e.y_q));
        chk("sel_chg_o_s", 32'(chg2), 32'(e.chg));
        chk("sel_chg_cnt_o_s", 32'(cnt2), 32'(e.cnt2));
        if (sel_chg_o) pulses++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_i);
    do_reset();

    // Latency: y_q holds 1 through edge N-1, y_o drops at once, y_q follows after edge N.
    step(1'b1, 1'b0, 1'b0);
    chk("lat_y_q_pre", 32'(y_q_o), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("lat_y_q_post", 32'(y_q_o), 32'd0);

    // Mid-operation reset clears accumulated state (count is 1 here).
    do_reset();

    // Change counting: 20 steps, sel every 5, a every 2, b every 3.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'(((i / 2) % 2)), 1'(((i / 3) % 2)), 1'(((i / 5) % 2) == 0));
    end
    chk("toggle_pulses", 32'(pulses), 32'd4);
    chk("toggle_cnt", 32'(sel_chg_cnt_o), 32'd4);

    // Saturation: six select changes.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'((i % 2) == 0));
    end
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    chk("sat_cnt8", 32'(sel_chg_cnt_o), 32'd6);

    // Data-only activity with sel held at 0.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'(i % 2), 1'((i / 2) % 2), 1'b0);
    end
    chk("data_pulses", 32'(pulses), 32'd0);
    chk("data_cnt", 32'(sel_chg_cnt_o), 32'd0);
    chk("data_y_q", 32'(y_q_o), 32'd1);

    repeat (2) @(negedge clk_i);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
